param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's 128-bit FIFO. It generalises data width, depth and almost-full/almost-empty thresholds. It adds a first-word-fall-through (FWFT) mode, a fill-level output and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, and its wren/rden/flag port set lets the existing FIFO UVM agents drive it.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 118 +++++++++++
 tb/tb_param_sync_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised FIFO family.
package fifo_pkg;

  typedef enum logic {STD, FWFT} fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int AW     = fifo_pkg::ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; only the pointers define validity.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width/depth/thresholds, optional first-word-fall-through,
// fill-level output and sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wren,
  input  logic [DATA_W-1:0]        i_wrdata,
  input  logic                     i_rden,
  input  logic                     i_clr_err,
  output logic [DATA_W-1:0]        o_rddata,
  output logic                     o_full,
  output logic                     o_alm_full,
  output logic                     o_empty,
  output logic                     o_alm_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int PTR_W = fifo_pkg::ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, ra, wa;
  logic [DATA_W-1:0] mem_rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign ra = i_rden & ~empty;
  assign wa = i_wren & (~full | ra);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wa) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (ra) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wa, ra})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A fresh error event in the same cycle as the clear keeps the flag set.
    overflow_d  = (i_wren & ~wa) | (overflow_q & ~i_clr_err);
    underflow_d = (i_rden & ~ra) | (underflow_q & ~i_clr_err);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wa),
    .waddr (wr_ptr_q),
    .wdata (i_wrdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] rddata_q, rddata_d;

      always_comb begin
        rddata_d = rddata_q;
        if (ra) rddata_d = mem_rdata;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rddata_q <= '0;
        else       rddata_q <= rddata_d;
      end

      assign o_rddata = rddata_q;
    end else begin : g_fwft
      // Head entry is shown directly; zero when there is nothing to show.
      assign o_rddata = empty ? '0 : mem_rdata;
    end
  endgenerate

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_alm_full  = (count_q >= CNT_W'(AF_THRESH));
  assign o_alm_empty = (count_q <= CNT_W'(AE_THRESH));
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Checks a standard-latency and an FWFT instance, driven in lockstep, against a queue-based model.
module tb_param_sync_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wrdata = '0;

  logic [DW-1:0] s_rddata, f_rddata;
  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;

  // Reference model: the FIFO is just an ordered queue of words.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_unf;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(int'(fifo_pkg::STD))) dut_std (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_clr_err(clr_err), .o_rddata(s_rddata), .o_full(s_full), .o_alm_full(s_afull),
    .o_empty(s_empty), .o_alm_empty(s_aempty), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(int'(fifo_pkg::FWFT))) dut_fwft (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_clr_err(clr_err), .o_rddata(f_rddata), .o_full(f_full), .o_alm_full(f_afull),
    .o_empty(f_empty), .o_alm_empty(f_aempty), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    int cnt;
    logic [DW-1:0] head;
    cnt  = q.size();
    head = (cnt > 0) ? q[0] : '0;
    chk({step, " std.count"},   DW'(s_count),  DW'(cnt));
    chk({step, " std.full"},    DW'(s_full),   DW'(cnt == DEPTH));
    chk({step, " std.afull"},   DW'(s_afull),  DW'(cnt >= AF));
    chk({step, " std.empty"},   DW'(s_empty),  DW'(cnt == 0));
    chk({step, " std.aempty"},  DW'(s_aempty), DW'(cnt <= AE));
    chk({step, " std.ovf"},     DW'(s_ovf),    DW'(m_ovf));
    chk({step, " std.unf"},     DW'(s_unf),    DW'(m_unf));
    chk({step, " std.rddata"},  s_rddata,      m_rd);
    chk({step, " fwft.count"},  DW'(f_count),  DW'(cnt));
    chk({step, " fwft.full"},   DW'(f_full),   DW'(cnt == DEPTH));
    chk({step, " fwft.afull"},  DW'(f_afull),  DW'(cnt >= AF));
    chk({step, " fwft.empty"},  DW'(f_empty),  DW'(cnt == 0));
    chk({step, " fwft.aempty"}, DW'(f_aempty), DW'(cnt <= AE));
    chk({step, " fwft.ovf"},    DW'(f_ovf),    DW'(m_ovf));
    chk({step, " fwft.unf"},    DW'(f_unf),    DW'(m_unf));
    chk({step, " fwft.rddata"}, f_rddata,      head);
  endtask

  // One clock: apply request, let the edge happen, advance the model, compare.
  task automatic cycle(input string step, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit c);
    bit ra, wa;
    wren = w; wrdata = d; rden = r; clr_err = c;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < DEPTH) || ra);
    @(posedge clk);
    #1;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(d);
    m_ovf = (w && !wa) || (m_ovf && !c);
    m_unf = (r && !ra) || (m_unf && !c);
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    check_all(step);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    int written;
    int iter;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    cycle("overflow", 1'b1, DW'(99), 1'b0, 1'b0);
    cycle("clr", 1'b0, '0, 1'b0, 1'b1);

    cycle("full_wr_rd", 1'b1, DW'('h100), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);

    cycle("empty_wr_rd", 1'b1, DW'('hA5), 1'b1, 1'b0);
    cycle("read_a5", 1'b0, '0, 1'b1, 1'b1);

    written = 0;
    iter = 0;
    while ((written < 40 || q.size() > 0) && iter < 400) begin
      bit w;
      w = (written < 40) && ($urandom_range(2) != 0);
      cycle("wrap", w, rnd_word(), $urandom_range(1) == 1, 1'b0);
      if (w && (q.size() > 0) && (q[q.size()-1] === wrdata)) written++;
      iter++;
    end
    chk("wrap.budget", DW'(iter < 400), DW'(1));
    cycle("clr2", 1'b0, '0, 1'b0, 1'b1);

    cycle("fwft_w11", 1'b1, DW'('h11), 1'b0, 1'b0);
    cycle("fwft_w22", 1'b1, DW'('h22), 1'b0, 1'b0);
    cycle("fwft_pop1", 1'b0, '0, 1'b1, 1'b0);
    cycle("fwft_pop2", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) cycle("refill", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("ovf_vs_clr", 1'b1, rnd_word(), 1'b0, 1'b1);
    cycle("clr3", 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++)
      cycle("random", $urandom_range(3) != 0, rnd_word(), $urandom_range(2) == 0,
            $urandom_range(9) == 0);

    while (q.size() > 0) cycle("predrain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle("burst", 1'b1, rnd_word(), 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    cycle("post_rst_w", 1'b1, DW'('h77), 1'b0, 1'b0);
    cycle("post_rst_r", 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
